// File: rtl/seq_ripple_adder.sv
// seq_ripple_adder: multi-cycle adder that sums CHUNK bits per clock, LSB chunk
// first, rippling the carry through a register between cycles.
// {C_Out, Sum} = a + b + cin, finished NCH = WIDTH/CHUNK cycles after start.
// Optional feature: define SEQ_ADDER_OVF_EN to add the registered signed-overflow
// output ovf.
module seq_ripple_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             C_Out
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, psum_reg, sum_reg;
    logic             carry_reg, cout_reg;
    logic [IDX_W-1:0] idx_reg;

    logic             accept, last_chunk;
    logic [NCH-1:0]   chunk_hit;
    logic [CHUNK-1:0] a_sel [NCH];
    logic [CHUNK-1:0] b_sel [NCH];
    logic [CHUNK-1:0] a_cur, b_cur, chunk_sum;
    logic             chunk_cout;
    logic [WIDTH-1:0] psum_next;

    // A new operation may only be taken while no addition is in flight.
    assign accept     = start && (state_reg != BUSY);
    assign last_chunk = (idx_reg == LAST_IDX);

    // Per-chunk slicing: one-hot chunk select, masked operand slices, and the
    // partial-sum merge that replaces only the chunk being processed.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chunk
            localparam logic [IDX_W-1:0] K = IDX_W'(gi);
            assign chunk_hit[gi] = (idx_reg == K);
            assign a_sel[gi] = chunk_hit[gi] ? a_reg[gi*CHUNK +: CHUNK] : '0;
            assign b_sel[gi] = chunk_hit[gi] ? b_reg[gi*CHUNK +: CHUNK] : '0;
            assign psum_next[gi*CHUNK +: CHUNK] =
                chunk_hit[gi] ? chunk_sum : psum_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Gather the active chunk and add it together with the rippled carry.
    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int k = 0; k < NCH; k++) begin
            a_cur = a_cur | a_sel[k];
            b_cur = b_cur | b_sel[k];
        end
        {chunk_cout, chunk_sum} = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_reg};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE/DONE accept start, BUSY runs until the last chunk.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last_chunk) state_next = DONE;
            DONE:    state_next = start ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then one chunk per BUSY cycle;
    // the result registers only move on the final chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            psum_reg  <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
        end else if (state_reg == BUSY) begin
            psum_reg  <= psum_next;
            carry_reg <= chunk_cout;
            idx_reg   <= idx_reg + 1'b1;
            if (last_chunk) begin
                sum_reg  <= psum_next;
                cout_reg <= chunk_cout;
            end
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    logic ovf_reg;

    // Signed overflow: operands agree in sign but the result sign differs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (!accept && (state_reg == BUSY) && last_chunk) begin
            ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                       (psum_next[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy  = (state_reg == BUSY);
    assign done  = (state_reg == DONE);
    assign Sum   = sum_reg;
    assign C_Out = cout_reg;

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Testbench for seq_ripple_adder: scoreboard-checked random and directed
// stimulus on an 8-bit/2-bit-chunk instance, plus a directed check of a
// 4-bit single-chunk instance. Define SEQ_ADDER_OVF_EN to also check ovf.
module tb_seq_ripple_adder;

    localparam int NCH = 4;

    typedef struct {
        int         start_e;
        int         done_cyc;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, c_out;
    logic [7:0] sum;
    logic       ovf;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;
    logic       ovf4;

    int   cyc = 0;
    int   last_e = -1000;
    int   rst_edge = -1;
    bit   check_en = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_txn = 0;
    exp_t sb_q[$];

    logic [7:0] exp_sum = '0;
    logic       exp_cout = 1'b0;
    logic       exp_ovf = 1'b0;

    seq_ripple_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .Sum(sum), .C_Out(c_out)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    seq_ripple_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .Sum(sum4), .C_Out(cout4)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

`ifndef SEQ_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf4 = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_checks++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, ex);
        end
    endtask

    // One clock of stimulus; the reference model decides whether the start is
    // taken (no operation in flight at that edge) and queues the expected result.
    task automatic drive(input logic st, input logic rs, input logic [7:0] ia,
                         input logic [7:0] ib, input logic ic);
        exp_t       t;
        logic [8:0] full;
        int         sv;
        int         e;
        @(posedge clk);
        #1;
        start = st;
        rst_n = rs;
        a     = ia;
        b     = ib;
        cin   = ic;
        e     = cyc + 1;
        if (!rs) begin
            last_e   = -1000;
            rst_edge = e;
        end else if (st && (e >= last_e + NCH + 1)) begin
            last_e     = e;
            full       = {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
            sv         = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
            t.start_e  = e;
            t.done_cyc = e + NCH;
            t.sum      = full[7:0];
            t.cout     = full[8];
            t.ovf      = (sv > 127) || (sv < -128);
            sb_q.push_back(t);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    // Monitor: applies reset to the model, then checks busy/done timing and the
    // held result every cycle, popping the scoreboard on each done pulse.
    always @(negedge clk) begin
        logic exp_done, exp_busy;
        if (cyc == rst_edge) begin
            for (int i = sb_q.size() - 1; i >= 0; i--)
                if (sb_q[i].start_e < rst_edge) sb_q.delete(i);
            exp_sum  = '0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
            check_en = 1;
        end
        if (check_en) begin
            if (sb_q.size() > 0 && sb_q[0].done_cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_missing at cycle %0d: got no done, expected done at cycle %0d",
                         cyc, sb_q[0].done_cyc);
                void'(sb_q.pop_front());
            end
            exp_done = (sb_q.size() > 0) && (sb_q[0].done_cyc == cyc);
            exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].done_cyc - NCH) &&
                       (cyc < sb_q[0].done_cyc);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_done) begin
                exp_sum  = sb_q[0].sum;
                exp_cout = sb_q[0].cout;
                exp_ovf  = sb_q[0].ovf;
                void'(sb_q.pop_front());
                n_txn++;
                $display("txn %0d cycle %0d: Sum=%h C_Out=%b ovf=%b (expected Sum=%h C_Out=%b ovf=%b)",
                         n_txn, cyc, sum, c_out, ovf, exp_sum, exp_cout, exp_ovf);
            end
            chk("Sum", 32'(sum), 32'(exp_sum));
            chk("C_Out", 32'(c_out), 32'(exp_cout));
`ifdef SEQ_ADDER_OVF_EN
            chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
        end
    end

    initial begin
        int  c0;
        bit  seen;
        // Reset, then a couple of idle cycles.
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        idle(2);
        // Carry through every chunk.
        drive(1'b1, 1'b1, 8'h01, 8'hFF, 1'b1);
        idle(6);
        // No carries at all.
        drive(1'b1, 1'b1, 8'hA5, 8'h5A, 1'b0);
        idle(6);
        // Signed overflow case.
        drive(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
        idle(6);
        // Start during BUSY must be ignored.
        drive(1'b1, 1'b1, 8'h10, 8'h20, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        idle(6);
        // Reset on the second BUSY cycle abandons the operation.
        drive(1'b1, 1'b1, 8'hC3, 8'h9E, 1'b1);
        drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h33, 8'h44, 1'b1);
        idle(6);
        // Start held high: back-to-back operations.
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        idle(6);
        // Random start, operands and occasional reset.
        for (int i = 0; i < 200; i++)
            drive(1'($urandom), ($urandom_range(0, 29) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
        idle(8);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        // Single-chunk instance: 4'hF + 4'h1 completes after one edge.
        @(posedge clk);
        #1;
        start4 = 1'b1;
        a4     = 4'hF;
        b4     = 4'h1;
        cin4   = 1'b0;
        c0     = cyc;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        chk("busy4", 32'(busy4), 32'd1);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (done4) seen = 1;
        end
        chk("done4_seen", 32'(seen), 32'd1);
        chk("done4_cycle", 32'(cyc), 32'(c0 + 2));
        chk("Sum4", 32'(sum4), 32'h0);
        chk("C_Out4", 32'(cout4), 32'd1);
`ifdef SEQ_ADDER_OVF_EN
        chk("ovf4", 32'(ovf4), 32'd0);
`endif
        @(negedge clk);
        chk("done4_single", 32'(done4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_ripple_adder.md
SEQ_RIPPLE_ADDER -- requirements
Module: seq_ripple_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; WIDTH SHALL be at least 1.
REQ-002 Parameter CHUNK, default 2, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to begin an addition; sampled on rising edge.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  single-cycle pulse marking that the result is valid.
REQ-011 Sum  output  WIDTH  result bits, registered.
REQ-012 C_Out  output  1  carry out of bit WIDTH-1, registered.
REQ-013 ovf  output  1  signed overflow flag; present only when SEQ_ADDER_OVF_EN is defined.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b and cin into internal registers, clear the chunk index to 0, and enter BUSY.
REQ-016 In BUSY, each rising edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of the captured operands plus the registered carry, store the CHUNK result bits into the internal partial sum, store the chunk carry-out as the new carry, and increment k; chunks are processed LSB first.
REQ-017 The edge that processes chunk NCH-1 SHALL load Sum and C_Out from the completed partial sum and final carry, and SHALL enter DONE.
REQ-018 done SHALL be 1 only while in DONE; DONE SHALL last exactly one cycle and return to IDLE unless start=1 (REQ-015).
REQ-019 Latency: done SHALL be high in the cycle following the NCH-th rising edge after the edge that sampled start.
REQ-020 busy SHALL be 1 exactly while in BUSY.
REQ-021 start while in BUSY SHALL be ignored; the captured operands SHALL NOT change.
REQ-022 a, b and cin SHALL be don't-care except at the edge where start is accepted.
REQ-023 Sum and C_Out SHALL hold the previous result through IDLE and BUSY, and SHALL change only at the REQ-017 edge.
REQ-024 Result: {C_Out, Sum} SHALL equal a + b + cin, computed at WIDTH+1 bits, with no truncation other than the carry going to C_Out.
REQ-025 When CHUNK = WIDTH, NCH = 1 and the operation SHALL take one BUSY cycle.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE and clear busy, done, Sum, C_Out, ovf, the partial sum, the carry register and the chunk index to 0.
REQ-027 Reset during BUSY SHALL abandon the operation; no done pulse SHALL follow.
REQ-028 rst_n has priority over start.

Configuration
REQ-029 Macro SEQ_ADDER_OVF_EN defined: port ovf SHALL exist and be loaded at the REQ-017 edge with (a[W-1]==b[W-1]) && (Sum[W-1]!=a[W-1]), using the captured operands; it SHALL hold until the next completion or reset.
REQ-030 Macro SEQ_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 WIDTH=8, CHUNK=2: a=8'h01, b=8'hFF, cin=1, start pulse -> busy high for 4 cycles, then done pulse, Sum=8'h01, C_Out=1.
REQ-032 WIDTH=8, CHUNK=2: a=8'hA5, b=8'h5A, cin=0 -> Sum=8'hFF, C_Out=0; with the macro defined, a=8'h7F, b=8'h01, cin=0 -> Sum=8'h80, ovf=1.
REQ-033 Start a=8'h10, b=8'h20, then start again with a=8'hFF during BUSY -> second start ignored, Sum=8'h30, exactly one done pulse.
REQ-034 rst_n low for one cycle on the 2nd BUSY cycle -> busy=0, Sum=0, C_Out=0, no done; a following start completes normally.
REQ-035 start held high through DONE -> back-to-back operations, done pulses spaced NCH+1 cycles apart, each result correct.
REQ-036 WIDTH=4, CHUNK=4: a=4'hF, b=4'h1, cin=0 -> done in the cycle after 1 edge, Sum=4'h0, C_Out=1.
